// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control FSM: state enum,
// packed control-flag bundle, datapath select encodings and the RV64 subset
// opcode / funct3 values the decoder dispatches on.
package ctrl_pkg;

  // Exception cause codes and the PC-source value that selects the trap vector.
  localparam logic       CAUSE_OPCODE   = 1'b0;
  localparam logic       CAUSE_OVERFLOW = 1'b1;
  localparam logic [1:0] EXC_VECTOR_SEL = 2'b10;

  // Major opcodes of the supported RV64 subset.
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Branch funct3 values that the compare flags can resolve.
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [1:0] {ALU_SUM, ALU_SUB, ALU_FUNCT, ALU_PASS_B} alu_op_t;
  typedef enum logic [1:0] {M2R_ALU_OUT, M2R_MDR, M2R_PC} m2r_t;
  typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALU_OUT = 2'b01, PCS_VECTOR = EXC_VECTOR_SEL} pc_src_t;
  typedef enum logic {A_PC, A_REG} src_a_t;
  typedef enum logic [1:0] {B_REG, B_FOUR, B_IMM} src_b_t;
  typedef enum logic [1:0] {SPL_D, SPL_W, SPL_H, SPL_B} splice_t;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    imem_read;
    logic    ir_write;
    logic    dmem_read;
    logic    dmem_write;
    m2r_t    mem_to_reg;
    pc_src_t pc_source;
    alu_op_t alu_op;
    src_a_t  alu_src_a;
    src_b_t  alu_src_b;
    logic    reg_write;
    splice_t store_splice;
    splice_t load_splice;
    logic    epc_write;
    logic    int_cause;
    logic    cause_write;
  } ctrl_flags_t;

  typedef enum logic [4:0] {
    S_START, S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEM_ADDR,
    S_LOAD_ISSUE, S_LOAD_WAIT, S_WRITE_BACK, S_STORE_ISSUE, S_STORE_WAIT,
    S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ARITH_COMPL, S_BRANCH,
    S_JUMP_LINK, S_JAL_COMPL, S_JALR_COMPL, S_EXCEPT, S_EXCEPT_WAIT, S_HALT
  } ctrl_state_t;

  // LD / LW / LH / LBU are the only loads the splice unit handles.
  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b010) || (f3 == 3'b001) || (f3 == 3'b100);
  endfunction

  // SD / SW / SH / SB.
  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b010) || (f3 == 3'b001) || (f3 == 3'b000);
  endfunction

  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

  // Byte/half select; only validated funct3 values reach the splice fields.
  function automatic splice_t splice_of(input logic [2:0] f3);
    case (f3)
      3'b011:  return SPL_D;
      3'b010:  return SPL_W;
      3'b001:  return SPL_H;
      default: return SPL_B;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Wait-state down-counter shared by FETCH_WAIT, LOAD_WAIT and STORE_WAIT.
// Loaded with N-1 by the issuing state, then decrements to zero and holds.
module ctrl_wait_counter #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_load_val,
  output logic              o_zero
);

  logic [WAIT_W-1:0] r_cnt;

  // Load on issue, otherwise count down and saturate at zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/control_fsm_param.sv
// Multicycle control FSM for the RV64 subset datapath. Counts memory wait
// states against imem_ready/dmem_ready, routes illegal encodings through a
// restartable exception path and parks in a sticky HALT on EBREAK.
// Optional: define CTRL_OVERFLOW_EXCEPT_EN to trap signed overflow of
// ADD/SUB/ADDI in ARITH_COMPL (cause 1) instead of writing the result.
module control_fsm_param
  import ctrl_pkg::*;
#(
  parameter int IMEM_WAIT = 1,
  parameter int DMEM_WAIT = 1,
  parameter int WAIT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_equal,
  input  logic        alu_greater,
  input  logic        alu_less,
  input  logic        alu_overflow,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output ctrl_flags_t ctrl,
  output logic        pc_write,
  output ctrl_state_t state_o,
  output logic        halted
);

  localparam logic [WAIT_W-1:0] IMEM_LOAD = WAIT_W'((IMEM_WAIT > 0) ? IMEM_WAIT - 1 : 0);
  localparam logic [WAIT_W-1:0] DMEM_LOAD = WAIT_W'((DMEM_WAIT > 0) ? DMEM_WAIT - 1 : 0);

  ctrl_state_t       r_state;
  logic              r_halted;
  logic              r_cause;
  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic              w_cnt_load;
  logic [WAIT_W-1:0] w_cnt_val;
  logic              w_cnt_zero;
  logic              w_fetch_done;
  logic              w_load_done;
  logic              w_store_done;
  logic              w_ovf_trap;
  logic              w_branch_cond;
  logic              w_unused;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];

  // Issue states arm the shared counter; with N=0 the ready is taken in the issue state.
  assign w_cnt_load = (r_state == S_FETCH) || (r_state == S_LOAD_ISSUE) || (r_state == S_STORE_ISSUE);
  assign w_cnt_val  = (r_state == S_FETCH) ? IMEM_LOAD : DMEM_LOAD;

  assign w_fetch_done = imem_ready && ((IMEM_WAIT == 0) ? (r_state == S_FETCH)
                                                        : (r_state == S_FETCH_WAIT && w_cnt_zero));
  assign w_load_done  = dmem_ready && ((DMEM_WAIT == 0) ? (r_state == S_LOAD_ISSUE)
                                                        : (r_state == S_LOAD_WAIT && w_cnt_zero));
  assign w_store_done = dmem_ready && ((DMEM_WAIT == 0) ? (r_state == S_STORE_ISSUE)
                                                        : (r_state == S_STORE_WAIT && w_cnt_zero));

`ifdef CTRL_OVERFLOW_EXCEPT_EN
  logic w_is_add_sub;
  assign w_is_add_sub = ((w_opcode == OPC_OP) || (w_opcode == OPC_OP_IMM)) && (w_funct3 == 3'b000);
  assign w_ovf_trap   = (r_state == S_ARITH_COMPL) && alu_overflow && w_is_add_sub;
  assign w_unused     = ^{instruction[19:15], instruction[11:7]};
`else
  assign w_ovf_trap   = 1'b0;
  assign w_unused     = ^{instruction[19:15], instruction[11:7], alu_overflow};
`endif

  ctrl_wait_counter #(.WAIT_W(WAIT_W)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_val),
    .o_zero    (w_cnt_zero)
  );

  // State register, sticky halt flag and latched exception cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_START;
      r_halted <= 1'b0;
      r_cause  <= CAUSE_OPCODE;
    end else begin
      case (r_state)
        S_START:       r_state <= S_FETCH;
        S_FETCH:       if (IMEM_WAIT != 0) r_state <= S_FETCH_WAIT;
                       else if (w_fetch_done) r_state <= S_DECODE;
        S_FETCH_WAIT:  if (w_fetch_done) r_state <= S_DECODE;
        S_DECODE: begin
          // Every trap leaving DECODE is an encoding fault.
          r_cause <= CAUSE_OPCODE;
          case (w_opcode)
            OPC_LOAD:               r_state <= load_f3_ok(w_funct3)   ? S_MEM_ADDR : S_EXCEPT;
            OPC_STORE:              r_state <= store_f3_ok(w_funct3)  ? S_MEM_ADDR : S_EXCEPT;
            OPC_OP_IMM, OPC_OP_IMM32: r_state <= S_EXEC_I;
            OPC_OP, OPC_OP32:       r_state <= S_EXEC_R;
            OPC_LUI, OPC_AUIPC:     r_state <= S_EXEC_U;
            OPC_BRANCH:             r_state <= branch_f3_ok(w_funct3) ? S_BRANCH : S_EXCEPT;
            OPC_JAL, OPC_JALR:      r_state <= S_JUMP_LINK;
            OPC_SYSTEM: begin
              if (instruction[31:20] == 12'd1) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end else begin
                r_state <= S_EXCEPT;
              end
            end
            default:                r_state <= S_EXCEPT;
          endcase
        end
        S_MEM_ADDR:    r_state <= (w_opcode == OPC_LOAD) ? S_LOAD_ISSUE : S_STORE_ISSUE;
        S_LOAD_ISSUE:  if (DMEM_WAIT != 0) r_state <= S_LOAD_WAIT;
                       else if (w_load_done) r_state <= S_WRITE_BACK;
        S_LOAD_WAIT:   if (w_load_done) r_state <= S_WRITE_BACK;
        S_WRITE_BACK:  r_state <= S_FETCH;
        S_STORE_ISSUE: if (DMEM_WAIT != 0) r_state <= S_STORE_WAIT;
                       else if (w_store_done) r_state <= S_FETCH;
        S_STORE_WAIT:  if (w_store_done) r_state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_EXEC_U: r_state <= S_ARITH_COMPL;
        S_ARITH_COMPL: begin
          if (w_ovf_trap) begin
            r_state <= S_EXCEPT;
            r_cause <= CAUSE_OVERFLOW;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_BRANCH:      r_state <= S_FETCH;
        S_JUMP_LINK:   r_state <= (w_opcode == OPC_JAL) ? S_JAL_COMPL : S_JALR_COMPL;
        S_JAL_COMPL, S_JALR_COMPL: r_state <= S_FETCH;
        S_EXCEPT:      r_state <= S_EXCEPT_WAIT;
        S_EXCEPT_WAIT: r_state <= S_FETCH;
        S_HALT:        r_state <= S_HALT;
        default:       r_state <= S_START;
      endcase
    end
  end

  // Control flags decoded from the current state and IR.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    ctrl        = '0;
    ctrl.alu_op = ALU_SUM;
    case (r_state)
      S_FETCH, S_FETCH_WAIT: begin
        ctrl.imem_read = 1'b1;
        ctrl.alu_src_a = A_PC;
        ctrl.alu_src_b = B_FOUR;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = w_fetch_done;
        ctrl.pc_write  = w_fetch_done;
      end
      S_DECODE: begin
        ctrl.alu_src_a = A_PC;
        ctrl.alu_src_b = B_IMM;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = A_REG;
        ctrl.alu_src_b = B_IMM;
      end
      S_LOAD_ISSUE, S_LOAD_WAIT: begin
        ctrl.dmem_read   = 1'b1;
        ctrl.load_splice = splice_of(w_funct3);
      end
      S_WRITE_BACK: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_to_reg  = M2R_MDR;
        ctrl.load_splice = splice_of(w_funct3);
      end
      S_STORE_ISSUE, S_STORE_WAIT: begin
        ctrl.dmem_write   = 1'b1;
        ctrl.store_splice = splice_of(w_funct3);
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ARITH_COMPL: begin
        // ALU operands stay set through ARITH_COMPL so alu_overflow describes this op.
        if (w_opcode == OPC_OP || w_opcode == OPC_OP32) begin
          ctrl.alu_src_a = A_REG;
          ctrl.alu_src_b = B_REG;
          ctrl.alu_op    = ALU_FUNCT;
        end else if (w_opcode == OPC_LUI) begin
          ctrl.alu_src_b = B_IMM;
          ctrl.alu_op    = ALU_PASS_B;
        end else if (w_opcode == OPC_AUIPC) begin
          ctrl.alu_src_a = A_PC;
          ctrl.alu_src_b = B_IMM;
        end else begin
          ctrl.alu_src_a = A_REG;
          ctrl.alu_src_b = B_IMM;
          ctrl.alu_op    = ALU_FUNCT;
        end
        if (r_state == S_ARITH_COMPL) begin
          ctrl.reg_write  = !w_ovf_trap;
          ctrl.mem_to_reg = M2R_ALU_OUT;
        end
      end
      S_BRANCH: begin
        ctrl.pc_write_cond = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.alu_src_a     = A_REG;
        ctrl.alu_src_b     = B_REG;
        ctrl.pc_source     = PCS_ALU_OUT;
      end
      S_JUMP_LINK: begin
        ctrl.alu_src_a = (w_opcode == OPC_JAL) ? A_PC : A_REG;
        ctrl.alu_src_b = B_IMM;
      end
      S_JAL_COMPL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCS_ALU_OUT;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
      end
      S_JALR_COMPL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCS_ALU;
        ctrl.alu_src_a  = A_REG;
        ctrl.alu_src_b  = B_IMM;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
      end
      S_EXCEPT: begin
        ctrl.epc_write   = 1'b1;
        ctrl.cause_write = 1'b1;
        ctrl.int_cause   = r_cause;
      end
      S_EXCEPT_WAIT: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_VECTOR;
      end
      default: ;
    endcase
  end

  // Branch outcome from the ALU compare flags for the four supported funct3 values.
  always_comb begin
    w_branch_cond = 1'b0;
    case (w_funct3)
      F3_BEQ:  w_branch_cond = alu_equal;
      F3_BNE:  w_branch_cond = !alu_equal;
      F3_BLT:  w_branch_cond = alu_less;
      F3_BGE:  w_branch_cond = alu_greater;
      default: w_branch_cond = 1'b0;
    endcase
  end

  assign pc_write = ctrl.pc_write | (ctrl.pc_write_cond & w_branch_cond);
  assign state_o  = r_state;
  assign halted   = r_halted;

endmodule

// File: tb/tb_control_fsm_param.sv
// Directed bench for control_fsm_param built with IMEM_WAIT=3, DMEM_WAIT=1.
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns later.
module tb_control_fsm_param;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        alu_equal, alu_greater, alu_less, alu_overflow;
  logic        imem_ready, dmem_ready;
  ctrl_flags_t ctrl;
  logic        pc_write;
  ctrl_state_t state_o;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_fsm_param #(.IMEM_WAIT(3), .DMEM_WAIT(1), .WAIT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .alu_equal   (alu_equal),
    .alu_greater (alu_greater),
    .alu_less    (alu_less),
    .alu_overflow(alu_overflow),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .ctrl        (ctrl),
    .pc_write    (pc_write),
    .state_o     (state_o),
    .halted      (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until the FSM reaches a state; an exhausted budget is a failure.
  task automatic run_to(input ctrl_state_t target, input int budget, input string tag);
    int n = 0;
    while (state_o !== target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (state_o !== target) begin
      errors++;
      $display("FAIL %s: state=%0d required=%0d", tag, state_o, target);
    end
  endtask

  // Wait for FETCH, present a new IR, then ride the fetch wait states to DECODE.
  task automatic fetch(input logic [31:0] instr);
    run_to(S_FETCH, 40, "reach FETCH");
    instruction = instr;
    imem_ready  = 1'b1;
    run_to(S_DECODE, 40, "reach DECODE");
  endtask

  task automatic expect_state(input ctrl_state_t want, input string tag);
    checks++;
    if (state_o !== want) begin
      errors++;
      $display("FAIL %s: state=%0d required=%0d", tag, state_o, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    expect_state(S_START, "reset state");
    checks++;
    if (ctrl !== '0 || pc_write !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: ctrl=%h pc_write=%b halted=%b required 0/0/0", ctrl, pc_write, halted);
    end
    reset = 1'b0;
    tick();
    expect_state(S_FETCH, "fetch after reset");
    checks++;
    if (ctrl.imem_read !== 1'b1) begin
      errors++;
      $display("FAIL fetch imem_read: got %b required 1", ctrl.imem_read);
    end
  endtask

  task automatic test_fetch_wait();
    // Ready from cycle 1: IR captured at cycle 3, DECODE at cycle 4.
    run_to(S_FETCH, 40, "fw1 FETCH");
    instruction = 32'h0000_0013;  // ADDI
    imem_ready  = 1'b1;
    tick();
    expect_state(S_FETCH_WAIT, "fw1 cycle1");
    tick();
    checks++;
    if (ctrl.ir_write !== 1'b0) begin
      errors++;
      $display("FAIL fw1 early ir_write: got %b required 0", ctrl.ir_write);
    end
    tick();
    checks++;
    if (ctrl.ir_write !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL fw1 cycle3 capture: ir_write=%b pc_write=%b required 1/1", ctrl.ir_write, pc_write);
    end
    tick();
    expect_state(S_DECODE, "fw1 DECODE at cycle4");
    tick();
    expect_state(S_EXEC_I, "addi EXEC_I");
    tick();
    checks++;
    if (state_o !== S_ARITH_COMPL || ctrl.reg_write !== 1'b1) begin
      errors++;
      $display("FAIL addi write: state=%0d reg_write=%b required %0d/1", state_o, ctrl.reg_write, S_ARITH_COMPL);
    end
    // Ready held low until cycle 6: DECODE at cycle 7.
    run_to(S_FETCH, 40, "fw2 FETCH");
    imem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    checks++;
    if (state_o !== S_FETCH_WAIT || ctrl.ir_write !== 1'b0) begin
      errors++;
      $display("FAIL fw2 stall: state=%0d ir_write=%b required %0d/0", state_o, ctrl.ir_write, S_FETCH_WAIT);
    end
    tick();
    imem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl.ir_write !== 1'b1) begin
      errors++;
      $display("FAIL fw2 cycle6 capture: ir_write=%b required 1", ctrl.ir_write);
    end
    tick();
    expect_state(S_DECODE, "fw2 DECODE at cycle7");
  endtask

  task automatic test_reset_mid_load();
    fetch(32'h0000_3003);  // LD
    dmem_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (state_o !== S_LOAD_ISSUE || ctrl.dmem_read !== 1'b1 || ctrl.load_splice !== SPL_D) begin
      errors++;
      $display("FAIL ld issue: state=%0d dmem_read=%b splice=%0d required %0d/1/%0d",
               state_o, ctrl.dmem_read, ctrl.load_splice, S_LOAD_ISSUE, SPL_D);
    end
    tick();
    tick();
    expect_state(S_LOAD_WAIT, "ld stalled in LOAD_WAIT");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state_o !== S_START || ctrl.reg_write !== 1'b0 || ctrl.dmem_read !== 1'b0 ||
          pc_write !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL mid-load reset %0d: state=%0d reg_write=%b dmem_read=%b pc_write=%b halted=%b",
                 i, state_o, ctrl.reg_write, ctrl.dmem_read, pc_write, halted);
      end
    end
    reset = 1'b0;
    tick();
    expect_state(S_FETCH, "fetch after mid-load reset");
  endtask

  task automatic test_load_store();
    dmem_ready = 1'b1;
    fetch(32'h0000_2003);  // LW
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (state_o !== S_WRITE_BACK || ctrl.reg_write !== 1'b1 || ctrl.mem_to_reg !== M2R_MDR ||
        ctrl.load_splice !== SPL_W) begin
      errors++;
      $display("FAIL lw writeback: state=%0d reg_write=%b m2r=%0d splice=%0d",
               state_o, ctrl.reg_write, ctrl.mem_to_reg, ctrl.load_splice);
    end
    fetch(32'h0000_1023);  // SH
    tick();
    tick();
    checks++;
    if (state_o !== S_STORE_ISSUE || ctrl.dmem_write !== 1'b1 || ctrl.store_splice !== SPL_H) begin
      errors++;
      $display("FAIL sh issue: state=%0d dmem_write=%b splice=%0d", state_o, ctrl.dmem_write, ctrl.store_splice);
    end
    tick();
    expect_state(S_STORE_WAIT, "sh STORE_WAIT");
    tick();
    expect_state(S_FETCH, "sh back to FETCH");
    fetch(32'h0000_7003);  // load funct3=111 is not supported
    tick();
    expect_state(S_EXCEPT, "bad load funct3 traps");
  endtask

  task automatic test_branch();
    alu_equal = 1'b1;
    fetch(32'h0000_0063);  // BEQ
    tick();
    checks++;
    if (state_o !== S_BRANCH || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL beq taken: state=%0d pc_write=%b required %0d/1", state_o, pc_write, S_BRANCH);
    end
    fetch(32'h0000_1063);  // BNE
    tick();
    checks++;
    if (state_o !== S_BRANCH || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL bne not taken: state=%0d pc_write=%b required %0d/0", state_o, pc_write, S_BRANCH);
    end
    alu_equal = 1'b0;
    alu_less  = 1'b1;
    fetch(32'h0000_4063);  // BLT
    tick();
    checks++;
    if (pc_write !== 1'b1) begin
      errors++;
      $display("FAIL blt taken: pc_write=%b required 1", pc_write);
    end
    alu_less = 1'b0;
    fetch(32'h0000_3063);  // funct3=011
    tick();
    checks++;
    if (state_o !== S_EXCEPT || ctrl.cause_write !== 1'b1 || ctrl.int_cause !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL bad branch: state=%0d cause_write=%b int_cause=%b pc_write=%b",
               state_o, ctrl.cause_write, ctrl.int_cause, pc_write);
    end
  endtask

  task automatic test_illegal_opcode();
    fetch(32'h0000_007F);
    tick();
    checks++;
    if (state_o !== S_EXCEPT || ctrl.epc_write !== 1'b1 || ctrl.cause_write !== 1'b1) begin
      errors++;
      $display("FAIL illegal EXCEPT: state=%0d epc_write=%b cause_write=%b", state_o, ctrl.epc_write, ctrl.cause_write);
    end
    tick();
    checks++;
    if (state_o !== S_EXCEPT_WAIT || ctrl.pc_source !== 2'b10 || ctrl.pc_write !== 1'b1) begin
      errors++;
      $display("FAIL illegal EXCEPT_WAIT: state=%0d pc_source=%b pc_write=%b required %0d/10/1",
               state_o, ctrl.pc_source, ctrl.pc_write, S_EXCEPT_WAIT);
    end
    tick();
    expect_state(S_FETCH, "resume after exception");
  endtask

  task automatic test_jal();
    fetch(32'h0000_006F);
    tick();
    expect_state(S_JUMP_LINK, "jal JUMP_LINK");
    tick();
    checks++;
    if (state_o !== S_JAL_COMPL || pc_write !== 1'b1 || ctrl.reg_write !== 1'b1 || ctrl.mem_to_reg !== M2R_PC) begin
      errors++;
      $display("FAIL jal compl: state=%0d pc_write=%b reg_write=%b m2r=%0d",
               state_o, pc_write, ctrl.reg_write, ctrl.mem_to_reg);
    end
  endtask

  task automatic test_overflow();
    fetch(32'h0000_0033);  // ADD, operands 0x7FFF...F + 1
    alu_overflow = 1'b1;
    tick();
    expect_state(S_EXEC_R, "add EXEC_R");
    tick();
`ifdef CTRL_OVERFLOW_EXCEPT_EN
    checks++;
    if (state_o !== S_ARITH_COMPL || ctrl.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL ovf suppress: state=%0d reg_write=%b required %0d/0", state_o, ctrl.reg_write, S_ARITH_COMPL);
    end
    tick();
    checks++;
    if (state_o !== S_EXCEPT || ctrl.int_cause !== 1'b1 || ctrl.cause_write !== 1'b1) begin
      errors++;
      $display("FAIL ovf trap: state=%0d int_cause=%b cause_write=%b required %0d/1/1",
               state_o, ctrl.int_cause, ctrl.cause_write, S_EXCEPT);
    end
`else
    checks++;
    if (state_o !== S_ARITH_COMPL || ctrl.reg_write !== 1'b1 || ctrl.mem_to_reg !== M2R_ALU_OUT) begin
      errors++;
      $display("FAIL ovf ignored: state=%0d reg_write=%b m2r=%0d required %0d/1/%0d",
               state_o, ctrl.reg_write, ctrl.mem_to_reg, S_ARITH_COMPL, M2R_ALU_OUT);
    end
    tick();
    expect_state(S_FETCH, "ovf ignored back to FETCH");
`endif
    alu_overflow = 1'b0;
  endtask

  task automatic test_ecall();
    fetch(32'h0000_0073);
    tick();
    checks++;
    if (state_o !== S_EXCEPT || ctrl.int_cause !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL ecall: state=%0d int_cause=%b halted=%b required %0d/0/0", state_o, ctrl.int_cause, halted, S_EXCEPT);
    end
  endtask

  task automatic test_halt();
    fetch(32'h0010_0073);  // EBREAK
    tick();
    instruction = 32'h0000_0033;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (state_o !== S_HALT || halted !== 1'b1 || ctrl !== '0 || pc_write !== 1'b0) begin
        errors++;
        $display("FAIL halt cycle %0d: state=%0d halted=%b ctrl=%h pc_write=%b", i, state_o, halted, ctrl, pc_write);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (state_o !== S_START || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt cleared by reset: state=%0d halted=%b", state_o, halted);
    end
  endtask

  initial begin
    reset        = 1'b1;
    instruction  = 32'h0000_0013;
    alu_equal    = 1'b0;
    alu_greater  = 1'b0;
    alu_less     = 1'b0;
    alu_overflow = 1'b0;
    imem_ready   = 1'b0;
    dmem_ready   = 1'b0;
    test_reset();
    test_fetch_wait();
    test_reset_mid_load();
    test_load_store();
    test_branch();
    test_illegal_opcode();
    test_jal();
    test_overflow();
    test_ecall();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
